// File: rtl/excp_commit_ctrl.sv
// Exception/interrupt commit sequencer: resolves writeback events, pulses flush/redirect, then drains the pipe.
// Optional feature: define EXCP_CNT_EN to enable the excp_count counter of taken exceptions.
module excp_commit_ctrl #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  output logic        ws_ready,
  input  logic [31:0] ws_pc,
  input  logic [5:0]  ws_excp,
  input  logic        ws_ertn,
  input  logic        has_int,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  output logic        excp_flush,
  output logic        ertn_flush,
  output logic [31:0] era_out,
  output logic [5:0]  ecode_out,
  output logic [8:0]  esubcode_out,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] excp_count
);

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_INE  = 6'h0D;
  localparam logic [5:0] ECODE_IPE  = 6'h0E;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        has_int_q;
  logic        is_ertn_q;
  logic [3:0]  drain_cnt;
  logic [31:0] era_q;
  logic [5:0]  ecode_q;
  logic        excp_evt;
  logic        ertn_evt;
  logic [5:0]  ecode_sel;

  // Event decode; only consumed while IDLE.
  always_comb begin
    excp_evt  = ws_valid & (has_int_q | (|ws_excp));
    ertn_evt  = ws_valid & ws_ertn & ~excp_evt;
    ecode_sel = ECODE_ALE;
    if (has_int_q)       ecode_sel = ECODE_INT;
    else if (ws_excp[0]) ecode_sel = ECODE_ADEF;
    else if (ws_excp[1]) ecode_sel = ECODE_INE;
    else if (ws_excp[2]) ecode_sel = ECODE_IPE;
    else if (ws_excp[3]) ecode_sel = ECODE_SYS;
    else if (ws_excp[4]) ecode_sel = ECODE_BRK;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (excp_evt || ertn_evt) state_nxt = FLUSH;
      FLUSH:   state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ws_ready       = 1'b0;
    excp_flush     = 1'b0;
    ertn_flush     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    case (state)
      IDLE:  ws_ready = ~excp_evt;
      FLUSH: begin
        excp_flush     = ~is_ertn_q;
        ertn_flush     = is_ertn_q;
        redirect_valid = 1'b1;
        redirect_pc    = is_ertn_q ? csr_era : csr_eentry;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      has_int_q <= 1'b0;
      is_ertn_q <= 1'b0;
      era_q     <= 32'h0;
      ecode_q   <= 6'h0;
      drain_cnt <= 4'd0;
    end else begin
      has_int_q <= has_int;
      if (state == IDLE && excp_evt) begin
        era_q     <= ws_pc;
        ecode_q   <= ecode_sel;
        is_ertn_q <= 1'b0;
      end else if (state == IDLE && ertn_evt) begin
        is_ertn_q <= 1'b1;
      end
      if (state == FLUSH)
        drain_cnt <= DRAIN_INIT;
      else if (state == DRAIN && drain_cnt != 4'd0)
        drain_cnt <= drain_cnt - 4'd1;
    end
  end

  assign era_out      = era_q;
  assign ecode_out    = ecode_q;
  assign esubcode_out = 9'h0;

`ifdef EXCP_CNT_EN
  logic [31:0] excp_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           excp_cnt_q <= 32'h0;
    else if (excp_flush) excp_cnt_q <= excp_cnt_q + 32'd1;
  end

  assign excp_count = excp_cnt_q;
`else
  assign excp_count = 32'h0;
`endif

endmodule

// File: doc/excp_commit_ctrl.md
# excp_commit_ctrl

Exception/interrupt commit sequencer between the writeback stage and the CSR file. It samples the writeback instruction's exception flags together with the CSR file's pending-interrupt level, and selects the highest-priority event. It then drives the one-cycle `excp_flush`/`ertn_flush` pulse with ERA/ECODE/ESUBCODE into the CSR file, issues the pipeline redirect, and holds writeback off until the pipeline has drained.

## Interface
- `DRAIN_CYCLES`, 2, cycles `ws_ready` stays low after the flush pulse; legal range 1–15.
- `clk` input 1: single clock.
- `reset` input 1: asynchronous, active-high.
- `ws_valid` input 1: writeback holds an instruction.
- `ws_ready` output 1: writeback may retire; an instruction retires when `ws_valid & ws_ready`.
- `ws_pc` input 32: PC of the writeback instruction.
- `ws_excp` input 6: exception flags.
  - bit0 ADEF, bit1 INE, bit2 IPE, bit3 SYS, bit4 BRK, bit5 ALE.
- `ws_ertn` input 1: writeback instruction is ERTN.
- `has_int` input 1: level from the CSR file.
- `csr_eentry` input 32: exception entry from the CSR file.
- `csr_era` input 32: ERA read from the CSR file.
- `excp_flush` output 1: one-cycle pulse to the CSR file.
- `ertn_flush` output 1: one-cycle pulse to the CSR file.
- `era_out` output 32: PC to save; valid with `excp_flush`.
- `ecode_out` output 6: exception code; valid with `excp_flush`.
- `esubcode_out` output 9: exception subcode; valid with `excp_flush`.
- `redirect_valid` output 1: one-cycle pulse, coincident with either flush pulse.
- `redirect_pc` output 32: new fetch PC.
- `excp_count` output 32: number of exceptions taken.

## Operation
- The FSM has three states: IDLE, FLUSH and DRAIN.
- `has_int_q` is `has_int` registered once; only `has_int_q` is used.
- In IDLE, `ws_ready = 1`. On `ws_valid`, events are resolved by fixed priority:
  - INT (`has_int_q`): ecode 0x00.
  - ADEF: ecode 0x08.
  - INE: ecode 0x0D.
  - IPE: ecode 0x0E.
  - SYS: ecode 0x0B.
  - BRK: ecode 0x0C.
  - ALE: ecode 0x09.
  - ERTN.
  - No event: normal retire.
- `esubcode_out` is always 0.
- Exception or interrupt:
  - Capture `ws_pc` into `era_out` and the selected code into `ecode_out`; move to FLUSH.
  - The instruction is not retired (`ws_ready` is 0 for that cycle).
  - In FLUSH: `excp_flush = 1`, `redirect_valid = 1`, `redirect_pc = csr_eentry` sampled at that cycle.
- ERTN with no higher event:
  - Move to FLUSH with `ertn_flush = 1`, `redirect_pc = csr_era`. The ERTN does retire.
- FLUSH always lasts exactly 1 cycle, then the FSM moves to DRAIN with a counter loaded to `DRAIN_CYCLES-1`.
- DRAIN decrements the counter each cycle and returns to IDLE after it reaches 0. `ws_ready = 0` throughout.
- `ws_ready` is a combinational function of state and the current-cycle event decode.

## Timing
- Reset state: IDLE. All outputs are 0 except `ws_ready`, which is 1 once out of reset. `has_int_q = 0`, `excp_count = 0`.
- Event seen in cycle T:
  - Flush and redirect pulse in T+1.
  - `ws_ready` is low from T through T+1+`DRAIN_CYCLES`.
  - IDLE is re-entered at T+2+`DRAIN_CYCLES`.
- An interrupt is taken no earlier than one cycle after `has_int` rises. It is taken on the first following cycle with `ws_valid` in IDLE.
- If `has_int` falls before a valid instruction arrives, no interrupt is taken.
- `ws_excp` and `has_int_q` are ignored outside IDLE.
- `ws_valid = 0` in IDLE: no action, regardless of the other inputs.
- Simultaneous events:
  - INT beats every exception flag and ERTN.
  - Any exception flag suppresses ERTN.
  - `excp_flush` and `ertn_flush` are never high together.
- `reset` asserted in any state: the FSM goes to IDLE immediately and asynchronously, and pulses are cut off.

## Configuration
- `EXCP_CNT_EN` defined:
  - `excp_count` increments by 1 (wrapping at 2^32) on every `excp_flush` cycle. Interrupts count; ERTN does not.
- Not defined: `excp_count` is tied to 0 and no counter flops exist.

## Test plan
- SYS at PC 0x1c000100, `csr_eentry` 0x1c008000:
  - One cycle later, `excp_flush = 1`, `era_out = 0x1c000100`, `ecode_out = 0x0B`, `redirect_pc = 0x1c008000`.
  - `ws_ready` is low for 2+`DRAIN_CYCLES` cycles.
- ERTN with `csr_era` 0x1c000104:
  - `ertn_flush` pulses once, `redirect_pc = 0x1c000104`, `excp_flush` stays 0.
- `has_int` raised in cycle 0, with an instruction at 0x1c000200 valid in cycle 2 also flagging ALE:
  - `ecode_out = 0x00`, `era_out = 0x1c000200`.
- ADEF+INE+ALE flagged together: `ecode_out = 0x08`. ERTN+BRK together: `excp_flush` with ecode 0x0C and no `ertn_flush`.
- `reset` asserted during DRAIN: state goes to IDLE and `ws_ready` is 1 on release, with no further flush pulse.
- With `EXCP_CNT_EN`, take 3 exceptions and 1 ERTN: `excp_count = 3`. Without it: `excp_count = 0`.
